rr_arbiter_lock: RTL

Parametrised N-requester round-robin arbiter with packet lock, the next-generation output-port arbiter for the NoC router. It sits between the per-input request lines and one output buffer. It registers a one-hot grant and holds it for the whole packet, until the tail flit transfers, the owner withdraws, or a hold timeout expires. Priority then rotates to one past the released owner, and re-arbitration happens in the same cycle, so there is no bubble between back-to-back packets.

---
 rtl/noc_pkg.sv | 18 +
 rtl/rr_arbiter_lock_if.sv | 29 ++
 rtl/rr_pick.sv | 37 +++
 rtl/rr_arbiter_lock.sv | 136 +++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: requester indices and output-arbiter state encoding.
package noc_pkg;

    localparam int NUM_PORTS  = 5;

    // Requester order at the router's output port arbiter
    localparam int PORT_PE    = 0;
    localparam int PORT_RIGHT = 1;
    localparam int PORT_LEFT  = 2;
    localparam int PORT_DOWN  = 3;
    localparam int PORT_UP    = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter_lock_if.sv
// Request/grant bundle between per-input request lines and one output-port arbiter.
// Latency and backpressure are defined by the arbiter; this is wiring only.
interface rr_arbiter_lock_if
    import noc_pkg::*;
#(
    parameter int N = NUM_PORTS
);
    localparam int IW = $clog2(N);

    logic          en;
    logic          out_ready;
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;
    logic          xfer;

    modport master (
        output en, out_ready, req, last,
        input  gnt, gnt_valid, gnt_idx, xfer
    );

    modport slave (
        input  en, out_ready, req, last,
        output gnt, gnt_valid, gnt_idx, xfer
    );

endinterface

// File: rtl/rr_pick.sv
// Masked round-robin priority selector: first eligible request at or after ptr.
// Purely combinational, zero latency; no backpressure of its own.
module rr_pick #(
    parameter int N  = 5,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [N-1:0]  elig;
    logic [IW-1:0] cidx;
    int            cand;

    always_comb begin
        elig   = req & ~mask;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = 0;
        cidx   = '0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            cidx = IW'(cand);
            if (!found && elig[cidx]) begin
                found        = 1'b1;
                onehot[cidx] = 1'b1;
                idx          = cidx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_lock.sv
// Round-robin output-port arbiter that locks the grant for a whole packet.
// Grant registered one cycle after request; re-arbitrates in the release cycle; out_ready=0 holds the grant.
module rr_arbiter_lock
    import noc_pkg::*;
#(
    parameter int N        = NUM_PORTS,
    parameter int LOCK_EN  = 1,
    parameter int MAX_HOLD = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    rr_arbiter_lock_if.slave  bus
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_t    state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [HW-1:0] hcnt, hcnt_nxt;
    logic [N-1:0]  gnt, gnt_nxt;
    logic [IW-1:0] gnt_idx, gnt_idx_nxt;

    logic          gnt_valid;
    logic          arb_ok;
    logic          owner_req;
    logic          owner_last;
    logic          xfer;
    logic          timeout;
    logic          release_now;
    logic [IW-1:0] rel_ptr;
    logic [IW-1:0] pick_ptr;
    logic [N-1:0]  pick_mask;
    logic [N-1:0]  pick_oh;
    logic [IW-1:0] pick_idx;
    logic          pick_found;

    assign gnt_valid  = |gnt;
    assign arb_ok     = bus.en && bus.out_ready;
    assign owner_req  = bus.req[gnt_idx];
    assign owner_last = bus.last[gnt_idx];
    assign xfer       = gnt_valid && arb_ok && owner_req;

    generate
        if (MAX_HOLD != 0) begin : g_timeout
            assign timeout = (hcnt == HW'(MAX_HOLD - 1));
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    // Tail, per-flit transfer, abandon or timeout all end the lock
    assign release_now = (state == ARB_LOCKED) &&
                         ((xfer && (owner_last || (LOCK_EN == 0))) || !owner_req || timeout);

    assign rel_ptr   = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;

    // On release the departing owner is masked so it cannot win its own release cycle
    assign pick_ptr  = release_now ? rel_ptr : ptr;
    assign pick_mask = release_now ? gnt : '0;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (pick_ptr),
        .mask   (pick_mask),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hcnt_nxt    = hcnt;
        gnt_nxt     = gnt;
        gnt_idx_nxt = gnt_idx;
        case (state)
            ARB_IDLE: begin
                gnt_nxt     = '0;
                gnt_idx_nxt = '0;
                hcnt_nxt    = '0;
                if (arb_ok && pick_found) begin
                    state_nxt   = ARB_LOCKED;
                    gnt_nxt     = pick_oh;
                    gnt_idx_nxt = pick_idx;
                end
            end
            ARB_LOCKED: begin
                if (release_now) begin
                    ptr_nxt  = rel_ptr;
                    hcnt_nxt = '0;
                    if (arb_ok && pick_found) begin
                        gnt_nxt     = pick_oh;
                        gnt_idx_nxt = pick_idx;
                    end else begin
                        state_nxt   = ARB_IDLE;
                        gnt_nxt     = '0;
                        gnt_idx_nxt = '0;
                    end
                end else if (!(&hcnt)) begin
                    hcnt_nxt = hcnt + 1'b1;
                end
            end
            default: begin
                state_nxt   = ARB_IDLE;
                gnt_nxt     = '0;
                gnt_idx_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ARB_IDLE;
            ptr     <= '0;
            hcnt    <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            hcnt    <= hcnt_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= gnt_idx_nxt;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.gnt_valid = gnt_valid;
    assign bus.gnt_idx   = gnt_idx;
    assign bus.xfer      = xfer;

endmodule
